// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, opcodes and IR capture pattern.
// Imported by jtag_tap_fsm and jtag_tap_controller.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  // Opcodes are zero-extended to IR_WIDTH; BYPASS is all ones.
  localparam int OPC_EXTEST = 0;
  localparam int OPC_IDCODE = 1;
  localparam int OPC_SAMPLE = 2;

  localparam int IR_CAPTURE = 1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller FSM with decoded per-state strobes.
// tlr flags the edge that enters (or stays in) Test-Logic-Reset.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       TMS,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr
);

  tap_state_e state_q, state_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
    endcase
  end

  assign state      = state_q;
  assign capture_dr = (state_q == CAP_DR);
  assign shift_dr   = (state_q == SH_DR);
  assign update_dr  = (state_q == UPD_DR);
  assign capture_ir = (state_q == CAP_IR);
  assign shift_ir   = (state_q == SH_IR);
  assign update_ir  = (state_q == UPD_IR);
  assign tlr        = (state_d == TLR);

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: IR, bypass, optional IDCODE (JTAG_TAP_IDCODE_EN),
// TDO mux and boundary-chain control decode.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          BSR_LEN    = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSR_TDO,
  output logic                TDO,
  output logic                TDO_En,
  output logic                Shift_or_Load,
  output logic                BSR_ClockEn,
  output logic                BSR_UpdateEn,
  output logic                Test_or_Normal,
  output logic [3:0]          Tap_State,
  output logic [IR_WIDTH-1:0] IR_Out
);

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OPC_EXTEST);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OPC_SAMPLE);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET  = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET  = OP_BYPASS;
`endif

  if (IR_WIDTH < 2 || BSR_LEN < 1 || !IDCODE_VAL[0]) begin : g_param_err
    $error("jtag_tap_controller: illegal parameter value");
  end

  tap_state_e state;
  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;
  logic tlr;

  jtag_tap_fsm u_fsm (
    .Clock      (Clock),
    .Reset      (Reset),
    .TMS        (TMS),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .tlr        (tlr)
  );

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] irsr_q, irsr_d;
  logic                byp_q, byp_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                sel_bsr;

  assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idc_q, idc_d;
  logic        sel_idc;

  assign sel_idc = (ir_q == OP_IDCODE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) idc_q <= IDCODE_VAL;
    else       idc_q <= idc_d;
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ir_q     <= IR_RESET;
      irsr_q   <= '0;
      byp_q    <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      irsr_q   <= irsr_d;
      byp_q    <= byp_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  always_comb begin
    ir_d     = ir_q;
    irsr_d   = irsr_q;
    byp_d    = byp_q;
    tdo_d    = tdo_q;
    tdo_en_d = shift_dr | shift_ir;
`ifdef JTAG_TAP_IDCODE_EN
    idc_d    = idc_q;
`endif
    if (capture_ir) irsr_d = IR_CAP;
    if (shift_ir) begin
      tdo_d  = irsr_q[0];
      irsr_d = {TDI, irsr_q[IR_WIDTH-1:1]};
    end
    if (update_ir) ir_d = irsr_q;
    if (tlr)       ir_d = IR_RESET;
    if (capture_dr) begin
      byp_d = 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      idc_d = IDCODE_VAL;
`endif
    end
    // Unselected data registers hold, so only the active one moves.
    if (shift_dr) begin
`ifdef JTAG_TAP_IDCODE_EN
      unique case (1'b1)
        sel_bsr: tdo_d = BSR_TDO;
        sel_idc: begin
          tdo_d = idc_q[0];
          idc_d = {TDI, idc_q[31:1]};
        end
        default: begin
          tdo_d = byp_q;
          byp_d = TDI;
        end
      endcase
`else
      if (sel_bsr) begin
        tdo_d = BSR_TDO;
      end else begin
        tdo_d = byp_q;
        byp_d = TDI;
      end
`endif
    end
  end

  assign TDO            = tdo_q;
  assign TDO_En         = tdo_en_q;
  assign Tap_State      = state;
  assign IR_Out         = ir_q;
  assign Test_or_Normal = (ir_q == OP_EXTEST);
  assign BSR_ClockEn    = sel_bsr & (capture_dr | shift_dr);
  assign Shift_or_Load  = sel_bsr & shift_dr;
  assign BSR_UpdateEn   = sel_bsr & update_dr;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized + directed bench for jtag_tap_controller against a
// table-driven TAP model and an 8-cell boundary chain.
module tb_jtag_tap_controller;
  import jtag_pkg::*;

  localparam int          IRW = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
  localparam int          BL  = 8;
`ifdef JTAG_TAP_IDCODE_EN
  localparam int RST_IR = 1;
`else
  localparam int RST_IR = 15;
`endif

  logic           Clock = 1'b0;
  logic           Reset = 1'b0;
  logic           TMS = 1'b0;
  logic           TDI = 1'b0;
  logic           bsr_tdo;
  logic           TDO, TDO_En;
  logic           Shift_or_Load, BSR_ClockEn, BSR_UpdateEn;
  logic           Test_or_Normal;
  logic [3:0]     Tap_State;
  logic [IRW-1:0] IR_Out;

  always #5 Clock = ~Clock;

  jtag_tap_controller #(
    .IR_WIDTH   (IRW),
    .IDCODE_VAL (IDV),
    .BSR_LEN    (BL)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .TMS            (TMS),
    .TDI            (TDI),
    .BSR_TDO        (bsr_tdo),
    .TDO            (TDO),
    .TDO_En         (TDO_En),
    .Shift_or_Load  (Shift_or_Load),
    .BSR_ClockEn    (BSR_ClockEn),
    .BSR_UpdateEn   (BSR_UpdateEn),
    .Test_or_Normal (Test_or_Normal),
    .Tap_State      (Tap_State),
    .IR_Out         (IR_Out)
  );

  // boundary chain: cell 0 fed by TDI, cell BL-1 returns to the TAP
  logic [BL-1:0] cap = '0;
  logic [BL-1:0] upd = '0;
  logic [BL-1:0] sys = '0;

  always @(posedge Clock) begin
    if (BSR_ClockEn) cap <= Shift_or_Load ? {cap[BL-2:0], TDI} : sys;
    if (BSR_UpdateEn) upd <= cap;
  end

  assign bsr_tdo = cap[BL-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  tap_state_e n0 [16];
  tap_state_e n1 [16];

  int        ms;
  bit [3:0]  m_ir, m_irsr;
  bit        m_byp, m_tdo, m_tden;
  bit [31:0] m_idc;

  function automatic bit m_bnd();
    return (m_ir == 0) || (m_ir == 2);
  endfunction

  function automatic bit m_idsel();
`ifdef JTAG_TAP_IDCODE_EN
    return m_ir == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    ms     = int'(TLR);
    m_ir   = 4'(RST_IR);
    m_irsr = 0;
    m_byp  = 0;
    m_tdo  = 0;
    m_tden = 0;
    m_idc  = IDV;
  endtask

  task automatic model_edge(input bit tms, input bit tdi, input bit bsr);
    int s;
    s = ms;
    if (s == CAP_IR) m_irsr = 1;
    if (s == SH_IR) begin
      m_tdo  = m_irsr[0];
      m_irsr = 4'((m_irsr >> 1) | (4'(tdi) << 3));
    end
    if (s == UPD_IR) m_ir = m_irsr;
    if (s == CAP_DR) begin
      m_byp = 0;
      m_idc = IDV;
    end
    if (s == SH_DR) begin
      if (m_bnd()) m_tdo = bsr;
      else if (m_idsel()) begin
        m_tdo = m_idc[0];
        m_idc = (m_idc >> 1) | (32'(tdi) << 31);
      end else begin
        m_tdo = m_byp;
        m_byp = tdi;
      end
    end
    m_tden = (s == SH_DR) || (s == SH_IR);
    ms = int'(tms ? n1[s] : n0[s]);
    if (ms == TLR) m_ir = 4'(RST_IR);
  endtask

  task automatic check_outs();
    bit b;
    b = m_bnd();
    chk("state", 32'(Tap_State), ms);
    chk("ir_out", 32'(IR_Out), 32'(m_ir));
    chk("tdo", 32'(TDO), 32'(m_tdo));
    chk("tdo_en", 32'(TDO_En), 32'(m_tden));
    chk("t_or_n", 32'(Test_or_Normal), 32'(m_ir == 0));
    chk("sol", 32'(Shift_or_Load), 32'(b && ms == SH_DR));
    chk("clk_en", 32'(BSR_ClockEn),
        32'(b && (ms == CAP_DR || ms == SH_DR)));
    chk("upd_en", 32'(BSR_UpdateEn), 32'(b && ms == UPD_DR));
  endtask

  // Called at posedge+1; drives inputs, then checks after the next edge.
  task automatic step(input bit tms, input bit tdi);
    TMS = tms;
    TDI = tdi;
    model_edge(tms, tdi, bsr_tdo);
    @(posedge Clock);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    chk("rst_state", 32'(Tap_State), 32'(TLR));
    @(posedge Clock);
    #1;
    check_outs();
    Reset = 1'b0;
  endtask

  task automatic load_ir(input bit [3:0] v, output bit [3:0] outb);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, v[i]);
      outb[i] = TDO;
    end
    step(1, 0);
    step(0, 0);
  endtask

  task automatic scan_dr(input bit [31:0] din, input int n,
                         output bit [31:0] dout, output int upd_cnt,
                         output int sol_cnt, output bit cap_en,
                         output bit cap_sol);
    dout    = 0;
    upd_cnt = 0;
    sol_cnt = 0;
    step(1, 0);
    step(0, 0);
    cap_en  = BSR_ClockEn;
    cap_sol = Shift_or_Load;
    step(0, 0);
    for (int i = 0; i < n; i++) begin
      sol_cnt += int'(Shift_or_Load);
      step(i == n - 1, din[i]);
      dout[i] = TDO;
    end
    step(1, 0);
    upd_cnt += int'(BSR_UpdateEn);
    step(0, 0);
    upd_cnt += int'(BSR_UpdateEn);
  endtask

  initial begin
    bit [3:0]    irb;
    bit [31:0]   dout, din;
    int          ucnt, scnt;
    bit          cen, csol;
    logic [BL-1:0] rev, snap;
    bit          hit;

    n0[TLR] = RTI;       n1[TLR] = TLR;
    n0[RTI] = RTI;       n1[RTI] = SEL_DR;
    n0[SEL_DR] = CAP_DR; n1[SEL_DR] = SEL_IR;
    n0[CAP_DR] = SH_DR;  n1[CAP_DR] = EX1_DR;
    n0[SH_DR] = SH_DR;   n1[SH_DR] = EX1_DR;
    n0[EX1_DR] = PAU_DR; n1[EX1_DR] = UPD_DR;
    n0[PAU_DR] = PAU_DR; n1[PAU_DR] = EX2_DR;
    n0[EX2_DR] = SH_DR;  n1[EX2_DR] = UPD_DR;
    n0[UPD_DR] = RTI;    n1[UPD_DR] = SEL_DR;
    n0[SEL_IR] = CAP_IR; n1[SEL_IR] = TLR;
    n0[CAP_IR] = SH_IR;  n1[CAP_IR] = EX1_IR;
    n0[SH_IR] = SH_IR;   n1[SH_IR] = EX1_IR;
    n0[EX1_IR] = PAU_IR; n1[EX1_IR] = UPD_IR;
    n0[PAU_IR] = PAU_IR; n1[PAU_IR] = EX2_IR;
    n0[EX2_IR] = SH_IR;  n1[EX2_IR] = UPD_IR;
    n0[UPD_IR] = RTI;    n1[UPD_IR] = SEL_DR;

    do_reset();
    chk("rst_ir", 32'(IR_Out), RST_IR);

    // EXTEST load; captured IR pattern shifts out 1 then 0
    step(0, 0);
    load_ir(4'b0000, irb);
    chk("extest_ir", 32'(IR_Out), 0);
    chk("extest_ton", 32'(Test_or_Normal), 1);
    chk("ir_cap_bits", 32'(irb[1:0]), 32'b01);

    // EXTEST scan of A5; captured system data comes back out first
    sys = BL'($urandom);
    scan_dr(32'hA5, 8, dout, ucnt, scnt, cen, csol);
    for (int i = 0; i < BL; i++) rev[BL-1-i] = upd[i];
    chk("cap_clken", 32'(cen), 1);
    chk("cap_sol", 32'(csol), 0);
    chk("sol_cycles", scnt, 8);
    chk("upd_pulse", ucnt, 1);
    chk("cells", 32'(rev), 32'hA5);
    for (int i = 0; i < BL; i++) rev[i] = sys[BL-1-i];
    chk("sys_out", dout, 32'(rev));

    // reset in the middle of a boundary shift: no update happens
    snap = upd;
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    do_reset();
    chk("abort_ton", 32'(Test_or_Normal), 0);
    chk("abort_upd", 32'(upd), 32'(snap));

    // BYPASS: one-bit delay with a leading 0
    step(0, 0);
    load_ir(4'b1111, irb);
    scan_dr(32'hC3, 8, dout, ucnt, scnt, cen, csol);
    chk("bypass_seq", dout, 32'h86);
    chk("bypass_upd", ucnt, 0);

    // IDCODE straight after reset
    do_reset();
    step(0, 0);
    din = $urandom;
    scan_dr(din, 32, dout, ucnt, scnt, cen, csol);
`ifdef JTAG_TAP_IDCODE_EN
    chk("idcode_seq", dout, IDV);
`else
    chk("idcode_seq", dout, {din[30:0], 1'b0});
`endif

    // five TMS=1 reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      hit = (ms == s);
      for (int k = 0; k < 300 && !hit; k++) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        hit = (ms == s);
      end
      chk("walk_reach", 32'(hit), 1);
      for (int k = 0; k < 5; k++) step(1, 1'($urandom_range(0, 1)));
      chk("tlr5", 32'(Tap_State), 32'(TLR));
    end

    // random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) sys = BL'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
